int_ctrl: RTL

Interrupt controller for the CPU, sitting directly downstream of the timer, PPU, serial and joypad blocks. It latches their single-`ce` interrupt pulses into the IF register (FF0F) and masks them with the IE register (FFFF). It presents a request/wake level to the CPU and runs the dispatch handshake that resolves the vector and clears the serviced IF bit. Dispatch resolution is deliberately late, so IE/IF writes made during dispatch change the outcome.

---
 rtl/int_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: latches source pulses into IF, masks them with IE, and runs
// the dispatch handshake that resolves a vector late and clears the serviced IF bit.
module int_ctrl #(
    parameter int unsigned RESOLVE_DLY = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       irq_vblank,
    input  logic       irq_stat,
    input  logic       irq_timer,
    input  logic       irq_serial,
    input  logic       irq_joypad,
    input  logic       cpu_sel_if,
    input  logic       cpu_sel_ie,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       int_req,
    input  logic       int_ack,
    output logic [7:0] int_vector,
    output logic       vec_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

    localparam logic [2:0] DLY_LOAD = 3'(RESOLVE_DLY - 1);

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [2:0] lowest_set(input logic [4:0] v);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) begin
                k = 3'(i);
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    state_e      state_q;
    logic [2:0]  dly_cnt_q;
    logic [2:0]  dly_cnt_d;
    logic [4:0]  if_q;
    logic [4:0]  if_d;
    logic [7:0]  ie_q;
    logic [7:0]  ie_d;
    logic [7:0]  int_vector_q;
    logic        vec_valid_q;

    logic [4:0]  irq_s;
    logic [4:0]  pend_s;
    logic [2:0]  k_s;
    logic        resolve_s;
    logic [4:0]  clr_mask_s;
    logic [4:0]  if_wr_val_s;
    logic [7:0]  vec_s;

    // Next-state of IF/IE: write first, then dispatch clear, then source pulses win.
    always_comb begin
        irq_s       = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
        pend_s      = ie_q[4:0] & if_q;
        k_s         = lowest_set(pend_s);
        vec_s       = 8'h40 + {2'b00, k_s, 3'b000};
        resolve_s   = ce && (state_q == ST_RESOLVE);
        clr_mask_s  = (resolve_s && (pend_s != 5'd0)) ? (5'd1 << k_s) : 5'd0;
        if_wr_val_s = (cpu_sel_if && cpu_wr) ? cpu_di[4:0] : if_q;
        if_d        = ce ? ((if_wr_val_s & ~clr_mask_s) | irq_s) : if_q;
        ie_d        = (ce && cpu_sel_ie && cpu_wr) ? cpu_di : ie_q;
        dly_cnt_d   = (dly_cnt_q != 3'd0) ? (dly_cnt_q - 3'd1) : 3'd0;
    end

    // Combinational register read-back.
    always_comb begin
        cpu_do = 8'hFF;
        if (cpu_sel_if) begin
            cpu_do = {3'b111, if_q};
        end else if (cpu_sel_ie) begin
            cpu_do = ie_q;
        end else begin
            cpu_do = 8'hFF;
        end
    end

    // Register state and dispatch FSM; resolution samples IE/IF at the start of the RESOLVE tick.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dly_cnt_q    <= 3'd0;
            if_q         <= 5'd0;
            ie_q         <= 8'h00;
            int_vector_q <= 8'h00;
            vec_valid_q  <= 1'b0;
        end else begin
            if_q <= if_d;
            ie_q <= ie_d;
            if (ce) begin
                case (state_q)
                    ST_IDLE: begin
                        vec_valid_q <= 1'b0;
                        if (int_ack) begin
                            dly_cnt_q <= DLY_LOAD;
                            state_q   <= (RESOLVE_DLY <= 1) ? ST_RESOLVE : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        dly_cnt_q <= dly_cnt_d;
                        if (dly_cnt_q <= 3'd1) begin
                            state_q <= ST_RESOLVE;
                        end
                    end
                    ST_RESOLVE: begin
                        int_vector_q <= (pend_s != 5'd0) ? vec_s : 8'h00;
                        vec_valid_q  <= 1'b1;
                        dly_cnt_q    <= 3'd0;
                        state_q      <= ST_IDLE;
                    end
                    default: begin
                        vec_valid_q <= 1'b0;
                        dly_cnt_q   <= 3'd0;
                        state_q     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign int_req    = |(ie_q[4:0] & if_q);
    assign int_vector = int_vector_q;
    assign vec_valid  = vec_valid_q;

endmodule
